// File: rtl/sram_8blk_ctrl.sv
// Sequencer for the 8-block 2048x20 precomputed-sum SRAM: streams the sums in, then serves parallel reads.
// Optional macro LOAD_CKSUM_EN adds a load_cksum output that sums every word accepted in the current LOAD.
module sram_8blk_ctrl #(
    parameter int DW        = 20,
    parameter int AW        = 8,
    parameter int NBLK      = 8,
    parameter int NWORDS    = 2048,
    parameter int DRAIN_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 loaded,
    output logic [1:0]           state,
    input  logic                 rd_req,
    output logic                 rd_ready,
    input  logic [NBLK*AW-1:0]   rd_addr,
    output logic                 rd_valid,
    output logic [DW-1:0]        sram_D,
    output logic [10:0]          sram_CADDR,
    output logic [NBLK*AW-1:0]   sram_A,
    output logic                 sram_WEN,
`ifdef LOAD_CKSUM_EN
    output logic [DW-1:0]        load_cksum,
`endif
    output logic                 sram_CEN
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int             CW         = 11;
    localparam logic [CW-1:0]  LAST_WORD  = CW'(NWORDS - 1);
    localparam int             DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    logic [1:0]     state_reg,  state_next;
    logic [CW-1:0]  count_reg,  count_next;
    logic           loaded_reg, loaded_next;
    logic [DCW-1:0] drain_reg,  drain_next;

    logic           wr_fire;
    logic           rd_fire;
    logic           rd_pend_reg;
    logic           rd_valid_reg;
    logic [DW-1:0]  sram_d_reg;
    logic [CW-1:0]  sram_caddr_reg;
    logic           sram_wen_reg;
    logic           sram_cen_reg;
    logic [AW-1:0]  sram_a_reg [NBLK];

    assign in_ready = (state_reg == S_LOAD);
    // load_start wins over a same-cycle read so the RUN->DRAIN edge never issues an access
    assign rd_ready = (state_reg == S_RUN) & ~load_start;
    assign wr_fire  = in_valid & in_ready;
    assign rd_fire  = rd_req & rd_ready;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        loaded_next = loaded_reg;
        drain_next  = drain_reg;
        case (state_reg)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LOAD;
                    count_next = '0;
                end else if (loaded_reg) begin
                    state_next = S_RUN;
                end
            end
            S_LOAD: begin
                if (wr_fire) begin
                    if (count_reg == LAST_WORD) begin
                        count_next  = '0;
                        loaded_next = 1'b1;
                        state_next  = S_RUN;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            S_RUN: begin
                if (load_start) begin
                    loaded_next = 1'b0;
                    drain_next  = '0;
                    state_next  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = S_LOAD;
                    count_next = '0;
                end else begin
                    drain_next = drain_reg + DCW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            loaded_reg     <= 1'b0;
            drain_reg      <= '0;
            rd_pend_reg    <= 1'b0;
            rd_valid_reg   <= 1'b0;
            sram_d_reg     <= '0;
            sram_caddr_reg <= '0;
            sram_wen_reg   <= 1'b1;
            sram_cen_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            loaded_reg     <= loaded_next;
            drain_reg      <= drain_next;
            // rd_valid trails the accepted read by one edge, lining up with Q from the negedge core
            rd_pend_reg    <= rd_fire;
            rd_valid_reg   <= rd_pend_reg;
            sram_wen_reg   <= ~wr_fire;
            sram_cen_reg   <= ~(wr_fire | rd_fire);
            sram_caddr_reg <= wr_fire ? count_reg : '0;
            if (wr_fire) begin
                sram_d_reg <= in_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk_addr
            always_ff @(posedge clk) begin
                if (rst) begin
                    sram_a_reg[gi] <= '0;
                end else if (rd_fire) begin
                    sram_a_reg[gi] <= rd_addr[gi*AW +: AW];
                end
            end
            assign sram_A[gi*AW +: AW] = sram_a_reg[gi];
        end
    endgenerate

`ifdef LOAD_CKSUM_EN
    logic          load_entry;
    logic [DW-1:0] cksum_reg;

    assign load_entry = (state_next == S_LOAD) && (state_reg != S_LOAD);

    always_ff @(posedge clk) begin
        if (rst || load_entry) begin
            cksum_reg <= '0;
        end else if (wr_fire) begin
            cksum_reg <= cksum_reg + in_data;
        end
    end

    assign load_cksum = cksum_reg;
`endif

    assign state      = state_reg;
    assign loaded     = loaded_reg;
    assign rd_valid   = rd_valid_reg;
    assign sram_D     = sram_d_reg;
    assign sram_CADDR = sram_caddr_reg;
    assign sram_WEN   = sram_wen_reg;
    assign sram_CEN   = sram_cen_reg;

endmodule

// File: tb/tb_sram_8blk_ctrl.sv
// Directed bench for sram_8blk_ctrl with a behavioural model of the 8-block SRAM behind it.
module tb_sram_8blk_ctrl;

    localparam int DW = 20;
    localparam int AW = 8;
    localparam int NBLK = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_start;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                loaded;
    logic [1:0]          state;
    logic                rd_req;
    logic                rd_ready;
    logic [NBLK*AW-1:0]  rd_addr;
    logic                rd_valid;
    logic [DW-1:0]       sram_D;
    logic [10:0]         sram_CADDR;
    logic [NBLK*AW-1:0]  sram_A;
    logic                sram_WEN;
    logic                sram_CEN;
`ifdef LOAD_CKSUM_EN
    logic [DW-1:0]       load_cksum;
`endif

    int checks = 0;
    int errors = 0;

    sram_8blk_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .loaded     (loaded),
        .state      (state),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .sram_D     (sram_D),
        .sram_CADDR (sram_CADDR),
        .sram_A     (sram_A),
        .sram_WEN   (sram_WEN),
`ifdef LOAD_CKSUM_EN
        .load_cksum (load_cksum),
`endif
        .sram_CEN   (sram_CEN)
    );

    always #5 clk = ~clk;

    // SRAM model: writes through CADDR, parallel per-block reads, Q valid after the next edge
    logic [DW-1:0] mem [2048];
    logic [DW-1:0] q   [NBLK];

    always @(posedge clk) begin
        if (sram_CEN === 1'b0 && sram_WEN === 1'b0) begin
            mem[sram_CADDR] <= sram_D;
        end
        if (sram_CEN === 1'b0 && sram_WEN === 1'b1) begin
            for (int b = 0; b < NBLK; b++) begin
                q[b] <= mem[{3'(b), sram_A[b*AW +: AW]}];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int base);
        for (int b = 0; b < NBLK; b++) begin
            rd_addr[b*AW +: AW] = 8'(base + b);
        end
    endtask

    // Expected block b word = mul * CADDR where CADDR = b*256 + base + b
    task automatic q_check(input int base, input int mul);
        logic [DW-1:0] e;
        for (int b = 0; b < NBLK; b++) begin
            e = DW'(mul * (b * 256 + base + b));
            chk("rd_q", 64'(q[b]), 64'(e));
        end
        $display("read base=%0h mul=%0d q0=%0h q7=%0h", base, mul, q[0], q[7]);
    endtask

    task automatic chk_reset_vals();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_cen", 64'(sram_CEN), 64'd1);
        chk("rst_wen", 64'(sram_WEN), 64'd1);
        chk("rst_caddr", 64'(sram_CADDR), 64'd0);
        chk("rst_d", 64'(sram_D), 64'd0);
        chk("rst_a", sram_A, 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
`ifdef LOAD_CKSUM_EN
        chk("rst_cksum", 64'(load_cksum), 64'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        tick();
        tick();
        chk_reset_vals();
        $display("reset done");
        rst = 1'b0;

        // Full load from IDLE, words = 3*i
        load_start = 1'b1;
        tick();
        chk("idle_to_load", 64'(state), 64'd1);
        load_start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            in_data = DW'(i * 3);
            tick();
            chk("full_wen", 64'(sram_WEN), 64'd0);
            chk("full_cen", 64'(sram_CEN), 64'd0);
            chk("full_caddr", 64'(sram_CADDR), 64'(i));
            chk("full_d", 64'(sram_D), 64'(i * 3));
            if (i < 2047) chk("full_state", 64'(state), 64'd1);
        end
        in_valid = 1'b0;
        chk("full_loaded", 64'(loaded), 64'd1);
        chk("full_state_run", 64'(state), 64'd2);
        $display("full load done state=%0d loaded=%0d", state, loaded);
        tick();
        chk("run_idle_cen", 64'(sram_CEN), 64'd1);
        chk("run_idle_wen", 64'(sram_WEN), 64'd1);
        chk("run_idle_caddr", 64'(sram_CADDR), 64'd0);
        chk("run_rd_ready", 64'(rd_ready), 64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd0);

        // Reload while two reads are in flight
        set_addr(8'h40); rd_req = 1'b1;
        tick();
        chk("rl_cen0", 64'(sram_CEN), 64'd0);
        chk("rl_rv0", 64'(rd_valid), 64'd0);
        set_addr(8'h50);
        tick();
        chk("rl_rv1", 64'(rd_valid), 64'd1);
        q_check(8'h40, 3);
        set_addr(8'h60); load_start = 1'b1;
        #1;
        chk("rl_rd_ready_blocked", 64'(rd_ready), 64'd0);
        tick();
        load_start = 1'b0; rd_req = 1'b0;
        chk("rl_state_drain", 64'(state), 64'd3);
        chk("rl_loaded", 64'(loaded), 64'd0);
        chk("rl_rv2", 64'(rd_valid), 64'd1);
        q_check(8'h50, 3);
        chk("rl_cen_blocked", 64'(sram_CEN), 64'd1);
        chk("rl_a_hold", 64'(sram_A[7:0]), 64'h50);
        tick();
        chk("rl_state_drain2", 64'(state), 64'd3);
        chk("rl_rv3", 64'(rd_valid), 64'd0);
        chk("rl_drain_cen", 64'(sram_CEN), 64'd1);
        tick();
        chk("rl_state_load", 64'(state), 64'd1);
        chk("rl_in_ready", 64'(in_ready), 64'd1);
        $display("reload drained into LOAD");

        // Gapped load, word = CADDR, handshake on odd cycles
        for (int c = 0; c < 4096; c++) begin
            in_valid = c[0];
            in_data = DW'(c / 2);
            tick();
            if (c[0]) begin
                chk("gap_wen", 64'(sram_WEN), 64'd0);
                chk("gap_cen", 64'(sram_CEN), 64'd0);
                chk("gap_caddr", 64'(sram_CADDR), 64'(c / 2));
                chk("gap_d", 64'(sram_D), 64'(c / 2));
            end else begin
                chk("gap_idle_wen", 64'(sram_WEN), 64'd1);
                chk("gap_idle_cen", 64'(sram_CEN), 64'd1);
                chk("gap_idle_caddr", 64'(sram_CADDR), 64'd0);
            end
            if (c < 4095) chk("gap_state", 64'(state), 64'd1);
        end
        in_valid = 1'b0;
        chk("gap_state_run", 64'(state), 64'd2);
        chk("gap_loaded", 64'(loaded), 64'd1);
        $display("gapped load done");

        // Three back-to-back reads
        for (int r = 0; r < 3; r++) begin
            set_addr(8'h10 * (r + 1)); rd_req = 1'b1;
            tick();
            chk("rd_cen", 64'(sram_CEN), 64'd0);
            chk("rd_wen", 64'(sram_WEN), 64'd1);
            chk("rd_a_blk7", 64'(sram_A[63:56]), 64'(8'h10 * (r + 1) + 7));
            chk("rd_valid_seq", 64'(rd_valid), 64'(r > 0));
            if (r > 0) q_check(8'h10 * r, 1);
        end
        rd_req = 1'b0;
        tick();
        chk("rd_valid_last", 64'(rd_valid), 64'd1);
        q_check(8'h30, 1);
        chk("rd_cen_idle", 64'(sram_CEN), 64'd1);
        tick();
        chk("rd_valid_off", 64'(rd_valid), 64'd0);

        // Mid-load reset at word 1000
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
        tick();
        chk("ml_state_load", 64'(state), 64'd1);
        in_valid = 1'b1; in_data = DW'(1);
        for (int i = 0; i < 1000; i++) tick();
        chk("ml_caddr_999", 64'(sram_CADDR), 64'd999);
        rst = 1'b1;
        tick();
        chk_reset_vals();
        $display("mid-load reset applied");
        rst = 1'b0; in_valid = 1'b0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ml_restart_state", 64'(state), 64'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            tick();
            chk("ml_caddr", 64'(sram_CADDR), 64'(i));
            chk("ml_d", 64'(sram_D), 64'd1);
        end
        in_valid = 1'b0;
        chk("ml_state_run", 64'(state), 64'd2);
        chk("ml_loaded", 64'(loaded), 64'd1);
`ifdef LOAD_CKSUM_EN
        chk("ml_cksum", 64'(load_cksum), 64'd2048);
        tick();
        chk("ml_cksum_hold", 64'(load_cksum), 64'd2048);
`endif
        $display("reload after reset done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
